dht11_responder: RTL and testbench
==================================

DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter CLK_PER_US, default 20, clock cycles per microsecond (CLK is 20 MHz).
REQ-002 Parameter START_MIN_US, default 500, minimum host-low width (us) accepted as a start request.
REQ-003 Parameter RESP_DELAY_US, default 30, delay (us) from host release to the first responder low drive.
REQ-004 CLK  input  1  system clock; all logic on its rising edge.
REQ-005 RST  input  1  reset; asynchronous assert, active-low (0 = reset).
REQ-006 DATA_IN  input  1  sampled level of the single-wire DHT bus (pulled up externally).
REQ-007 DATA_OE  output  1  1 = drive bus low; 0 = release bus (top level ties the pad to 0 when DATA_OE = 1, else high-Z).
REQ-008 HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT  input  8 each  measurement bytes to transmit.
REQ-009 BUSY  output  1  high from start-request acceptance until frame end or abort.
REQ-010 FRAME_DONE  output  1  one-cycle pulse after a complete 40-bit frame.
REQ-011 COLLISION  output  1  one-cycle pulse when a frame is aborted because of a bus collision.

Function
REQ-012 DATA_IN SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized level (2-cycle input latency).
REQ-013 States: IDLE, HOST_LOW, WAIT_RESP, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-014 IDLE: DATA_OE = 0; on synchronized low -> HOST_LOW and clear the microsecond counter.
REQ-015 HOST_LOW: count low time in us, saturating (no wrap); on a rising level, count >= START_MIN_US -> WAIT_RESP, otherwise -> IDLE silently.
REQ-016 On HOST_LOW -> WAIT_RESP: latch the four bytes plus checksum = (HUM_INT+HUM_FLOAT+TEMP_INT+TEMP_FLOAT) mod 256 into a 40-bit shift register and assert BUSY.
REQ-017 Input bytes that change after latching SHALL NOT affect the frame in progress.
REQ-018 WAIT_RESP: release for RESP_DELAY_US, then -> ACK_LOW.
REQ-019 ACK_LOW: drive low for 80 us, then -> ACK_HIGH.
REQ-020 ACK_HIGH: release for 80 us, then -> BIT_LOW.
REQ-021 BIT_LOW: drive low for 50 us, then -> BIT_HIGH.
REQ-022 BIT_HIGH: release for 26 us if the current bit is 0, or 70 us if it is 1.
REQ-023 At the end of BIT_HIGH: bit index < 39 -> shift and go to BIT_LOW; bit index = 39 -> END_LOW.
REQ-024 Bit order: byte order HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, checksum; MSB first within each byte.
REQ-025 END_LOW: drive low for 50 us, then release, pulse FRAME_DONE, deassert BUSY, and -> IDLE on the same edge.
REQ-026 All durations SHALL be exact to +/-1 clock cycle: duration_us*CLK_PER_US cycles, timed from the state-entry edge.
REQ-027 Collision: in WAIT_RESP, ACK_HIGH or BIT_HIGH, a synchronized low lasting >= 2 consecutive cycles (after 2-cycle synchronizer settling from the release) SHALL release the bus, pulse COLLISION, deassert BUSY and go to IDLE.
REQ-028 After a collision, IDLE SHALL not re-arm until the synchronized line has been high for >= 1 cycle.
REQ-029 A host holding the line low indefinitely SHALL keep the block in HOST_LOW with a saturated counter and DATA_OE = 0.
REQ-030 No state other than ACK_LOW, BIT_LOW and END_LOW SHALL assert DATA_OE.

Reset
REQ-031 RST = 0 SHALL immediately (asynchronously) force IDLE, DATA_OE = 0, BUSY = 0, FRAME_DONE = 0, COLLISION = 0, counters = 0, shift register = 0, synchronizer = 1.
REQ-032 Reset asserted mid-frame SHALL release the bus within the same cycle; no frame resumes after reset release.
REQ-033 After RST deasserts, the first start request SHALL be recognized only from a fresh high-to-low edge.

Verification
REQ-034 Host low 18 ms, release; bytes 0x37,0x00,0x19,0x00 -> 30 us, 80 us low, 80 us high, 40 bits ending with checksum 0x50, 50 us low, FRAME_DONE pulse.
REQ-035 Host low 200 us, release -> no DATA_OE assertion, BUSY stays 0.
REQ-036 Bytes 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC; all 32 data bits have 70 us highs; checksum bit 7..0 high widths 70,70,70,70,70,70,26,26 us.
REQ-037 Host pulls line low for 5 us during bit 10 BIT_HIGH -> COLLISION pulse, DATA_OE = 0, BUSY = 0, no FRAME_DONE.
REQ-038 RST pulsed low during ACK_LOW -> DATA_OE drops same cycle; after release, no output until a new valid start request.
REQ-039 Change TEMP_INT from 0x19 to 0x20 during bit 5 -> transmitted frame still carries 0x19 with the original checksum.

Source files
------------

// File: rtl/dht11_responder.sv
// dht11_responder: answers a DHT11 host start request with the ack pulses and a 40-bit
//   measurement frame (4 bytes + checksum), driving the open-drain bus low via DATA_OE.
// Latency: 2-cycle input synchronizer plus 1 FSM cycle; durations are exact cycle multiples.
// Backpressure: none. Another driver on a released phase aborts the frame with COLLISION.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   DATA_IN    raw bus level (externally pulled up)
//   DATA_OE    1 = pull bus low, 0 = release
//   HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT  bytes sent, latched when a start is accepted
//   BUSY       high from start acceptance to frame end or abort
//   FRAME_DONE one-cycle pulse after the last bit's end-low
//   COLLISION  one-cycle pulse when a frame is aborted by a foreign low
module dht11_responder #(
    parameter int CLK_PER_US    = 20,
    parameter int START_MIN_US  = 500,
    parameter int RESP_DELAY_US = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA_IN,
    output logic       DATA_OE,
    input  logic [7:0] HUM_INT,
    input  logic [7:0] HUM_FLOAT,
    input  logic [7:0] TEMP_INT,
    input  logic [7:0] TEMP_FLOAT,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       COLLISION
);

    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_W  = 16;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]  US_MAX    = {US_W{1'b1}};
    localparam logic [US_W-1:0]  START_MIN = US_W'(START_MIN_US);
    // Timer compare values are "duration - 1": the state ends on the tick that
    // completes the last microsecond.
    localparam logic [US_W-1:0]  T_RESP    = US_W'(RESP_DELAY_US - 1);
    localparam logic [US_W-1:0]  T_ACK     = US_W'(80 - 1);
    localparam logic [US_W-1:0]  T_LOW     = US_W'(50 - 1);
    localparam logic [US_W-1:0]  T_ZERO    = US_W'(26 - 1);
    localparam logic [US_W-1:0]  T_ONE     = US_W'(70 - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        WAIT_RESP,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              sync_1;
    logic              sync_2;
    logic              data_s;
    logic [PRE_W-1:0]  pre_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [1:0]        settle_cnt;
    logic              low_seen;
    logic              armed;
    logic [39:0]       shift_q;
    logic [5:0]        bit_idx;
    logic              frame_done_q;
    logic              collision_q;

    logic              us_tick;
    logic              settled;
    logic              collide;
    logic              listen;
    logic [US_W-1:0]   t_bit_high;
    logic [7:0]        csum;
    logic              load_frame;
    logic              shift_frame;
    logic              done_nxt;
    logic              coll_nxt;

    assign data_s     = sync_2;
    assign us_tick    = (pre_cnt == PRE_LAST);
    // The synchronizer lags the pad by two cycles, so the first two samples after
    // any state entry still show whatever the bus did before the entry edge.
    assign settled    = (settle_cnt == 2'd2);
    assign collide    = settled && !data_s && low_seen;
    assign listen     = (state == WAIT_RESP) || (state == ACK_HIGH) || (state == BIT_HIGH);
    assign t_bit_high = shift_q[39] ? T_ONE : T_ZERO;
    assign csum       = HUM_INT + HUM_FLOAT + TEMP_INT + TEMP_FLOAT;

    assign DATA_OE    = (state == ACK_LOW) || (state == BIT_LOW) || (state == END_LOW);
    assign BUSY       = (state != IDLE) && (state != HOST_LOW);
    assign FRAME_DONE = frame_done_q;
    assign COLLISION  = collision_q;

    always_comb begin
        state_nxt   = state;
        load_frame  = 1'b0;
        shift_frame = 1'b0;
        done_nxt    = 1'b0;
        coll_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !data_s) begin
                    state_nxt = HOST_LOW;
                end
            end
            HOST_LOW: begin
                if (data_s) begin
                    if (us_cnt >= START_MIN) begin
                        state_nxt  = WAIT_RESP;
                        load_frame = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_RESP: begin
                if (us_tick && (us_cnt == T_RESP)) begin
                    state_nxt = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (us_tick && (us_cnt == T_ACK)) begin
                    state_nxt = ACK_HIGH;
                end
            end
            ACK_HIGH: begin
                if (us_tick && (us_cnt == T_ACK)) begin
                    state_nxt = BIT_LOW;
                end
            end
            BIT_LOW: begin
                if (us_tick && (us_cnt == T_LOW)) begin
                    state_nxt = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (us_tick && (us_cnt == t_bit_high)) begin
                    if (bit_idx == 6'd39) begin
                        state_nxt = END_LOW;
                    end else begin
                        state_nxt   = BIT_LOW;
                        shift_frame = 1'b1;
                    end
                end
            end
            END_LOW: begin
                if (us_tick && (us_cnt == T_LOW)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A foreign low while we are released wins over any timer expiry.
        if (listen && collide) begin
            state_nxt   = IDLE;
            shift_frame = 1'b0;
            coll_nxt    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            frame_done_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= done_nxt;
            collision_q  <= coll_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            pre_cnt    <= '0;
            us_cnt     <= '0;
            settle_cnt <= '0;
            low_seen   <= 1'b0;
            armed      <= 1'b0;
            shift_q    <= '0;
            bit_idx    <= '0;
        end else begin
            sync_1 <= DATA_IN;
            sync_2 <= sync_1;

            // All timers restart on the edge that enters a new state.
            if (state_nxt != state) begin
                pre_cnt    <= '0;
                us_cnt     <= '0;
                settle_cnt <= '0;
                low_seen   <= 1'b0;
            end else begin
                pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
                if (us_tick && (us_cnt != US_MAX)) begin
                    us_cnt <= us_cnt + 1'b1;
                end
                if (!settled) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end else begin
                    low_seen <= !data_s;
                end
            end

            // A start is only taken from a genuine high-to-low edge: the line must be
            // seen high (with real, settled samples) while idle before a low counts.
            // This covers reset release, our own end-low and a host still holding
            // the line after a collision.
            armed <= (state == IDLE) && (armed || (settled && data_s));

            if (load_frame) begin
                shift_q <= {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, csum};
                bit_idx <= '0;
            end else if (shift_frame) begin
                shift_q <= {shift_q[38:0], 1'b0};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
module tb_dht11_responder;

    localparam int K       = 2;      // clock cycles per microsecond in this bench
    localparam int RESP    = 30;
    localparam int MAX_CYC = 14000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       host_low = 1'b1;
    logic       DATA_IN;
    logic       DATA_OE;
    logic       BUSY;
    logic       FRAME_DONE;
    logic       COLLISION;
    logic [7:0] HUM_INT = 8'h00;
    logic [7:0] HUM_FLOAT = 8'h00;
    logic [7:0] TEMP_INT = 8'h00;
    logic [7:0] TEMP_FLOAT = 8'h00;

    // Open-drain bus with pull-up: low if either side pulls.
    assign DATA_IN = !(host_low || DATA_OE);

    dht11_responder #(
        .CLK_PER_US   (K),
        .START_MIN_US (500),
        .RESP_DELAY_US(RESP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DATA_IN   (DATA_IN),
        .DATA_OE   (DATA_OE),
        .HUM_INT   (HUM_INT),
        .HUM_FLOAT (HUM_FLOAT),
        .TEMP_INT  (TEMP_INT),
        .TEMP_FLOAT(TEMP_FLOAT),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE),
        .COLLISION (COLLISION)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] hf;
        logic [7:0] ti;
        logic [7:0] tf;
        logic [7:0] cs;      // expected checksum
        int         mode;    // 0 plain frame, 1 TEMP_INT changes during bit 5
        int         low_us;  // host start pulse width
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Capture results, one sample of DATA_OE per cycle after host release.
    logic samp[$];
    int   done_idx, coll_idx, n_done, n_coll, busy_rise, busy_at_done, busy_at_coll;
    int   coll_at, oe_after_coll;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            if (lo == hi) $display("FAIL %s: got %0d, expected %0d", name, act, lo);
            else          $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Host pulls the line low for 'us' microseconds, then releases just after a rising edge.
    task automatic host_start(input int us);
        @(posedge CLK);
        #1 host_low = 1'b1;
        repeat (us * K) @(posedge CLK);
        #1;
        chk("oe_during_host_low", int'(DATA_OE), 0, 0);
        chk("busy_during_host_low", int'(BUSY), 0, 0);
        host_low = 1'b0;
    endtask

    // Any drive or BUSY over a window means an unwanted frame started.
    task automatic watch_quiet(input string name, input int cycles);
        int act = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            if (DATA_OE || BUSY || FRAME_DONE) act++;
        end
        chk(name, act, 0, 0);
    endtask

    task automatic capture(input int mode);
        int   rises = 0;
        logic prev_oe = 1'b0;
        samp.delete();
        done_idx = -1; coll_idx = -1; n_done = 0; n_coll = 0;
        busy_rise = -1; busy_at_done = -1; busy_at_coll = -1;
        coll_at = -1; oe_after_coll = 0;
        for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
            @(negedge CLK);
            samp.push_back(DATA_OE);
            if (DATA_OE && !prev_oe) rises++;
            prev_oe = DATA_OE;
            if (BUSY && busy_rise < 0) busy_rise = cyc;
            if (FRAME_DONE) begin
                n_done++;
                if (done_idx < 0) begin done_idx = cyc; busy_at_done = int'(BUSY); end
            end
            if (COLLISION) begin
                n_coll++;
                if (coll_idx < 0) begin coll_idx = cyc; busy_at_coll = int'(BUSY); end
            end
            if (coll_idx >= 0 && DATA_OE) oe_after_coll++;
            // rise 1 is the ack; rise n+2 starts bit n
            if (mode == 1 && rises == 7) TEMP_INT = 8'h20;
            if (mode == 2 && rises == 12 && !DATA_OE && coll_at < 0) coll_at = cyc + 10;
            if (coll_at >= 0) host_low = (cyc >= coll_at) && (cyc < coll_at + 5 * K);
            if (done_idx >= 0) break;
            if (coll_at >= 0 && cyc > coll_at + 5 * K + 200) break;
        end
        host_low = 1'b0;
    endtask

    // Reference: sensor waveform computed directly from the frame bits, as
    // alternating driven/released widths starting at the first ack drive.
    task automatic check_frame(input logic [39:0] fr, input string tag);
        int     exp_r[$];
        int     act[$];
        int     lead, lim, run, val, nseg;
        logic [39:0] dec;
        string  bname[5];
        bname[0] = "hum_int"; bname[1] = "hum_float"; bname[2] = "temp_int";
        bname[3] = "temp_float"; bname[4] = "checksum";

        exp_r.push_back(80 * K);
        exp_r.push_back(80 * K);
        for (int b = 0; b < 40; b++) begin
            exp_r.push_back(50 * K);
            exp_r.push_back((fr[39 - b] ? 70 : 26) * K);
        end
        exp_r.push_back(50 * K);

        lead = 0;
        while (lead < samp.size() && !samp[lead]) lead++;
        // 2 synchronizer cycles + 1 FSM cycle before the response delay starts
        chk({tag, " resp_delay"}, lead, RESP * K + 2, RESP * K + 4);

        lim = (done_idx >= 0) ? done_idx : samp.size();
        run = 0; val = 1;
        for (int i = lead; i < lim; i++) begin
            if (int'(samp[i]) == val) run++;
            else begin act.push_back(run); run = 1; val = int'(samp[i]); end
        end
        if (run > 0) act.push_back(run);

        chk({tag, " segments"}, act.size(), exp_r.size(), exp_r.size());
        nseg = (act.size() < exp_r.size()) ? act.size() : exp_r.size();
        for (int i = 0; i < nseg; i++)
            chk($sformatf("%s seg%0d", tag, i), act[i], exp_r[i] - 1, exp_r[i] + 1);

        dec = '0;
        for (int b = 0; b < 40; b++)
            if (3 + 2 * b < act.size()) dec[39 - b] = (act[3 + 2 * b] > 48 * K);
        for (int j = 0; j < 5; j++)
            chk({tag, " ", bname[j]}, int'(dec[39 - 8 * j -: 8]), int'(fr[39 - 8 * j -: 8]),
                int'(fr[39 - 8 * j -: 8]));

        chk({tag, " frame_done_count"}, n_done, 1, 1);
        chk({tag, " collision_count"}, n_coll, 0, 0);
        chk({tag, " busy_rise"}, busy_rise, 2, 4);
        chk({tag, " busy_at_done"}, busy_at_done, 0, 0);
        if (done_idx > 0) chk({tag, " drive_before_done"}, int'(samp[done_idx - 1]), 1, 1);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{hi:8'h37, hf:8'h00, ti:8'h19, tf:8'h00, cs:8'h50, mode:0, low_us:600};
        vecs[1] = '{hi:8'hFF, hf:8'hFF, ti:8'hFF, tf:8'hFF, cs:8'hFC, mode:0, low_us:520};
        vecs[2] = '{hi:8'hA5, hf:8'h5A, ti:8'h00, tf:8'h01, cs:8'h00, mode:0, low_us:560};
        vecs[3].hi = 8'($urandom); vecs[3].hf = 8'($urandom);
        vecs[3].ti = 8'($urandom); vecs[3].tf = 8'($urandom);
        vecs[3].cs = 8'((int'(vecs[3].hi) + int'(vecs[3].hf) + int'(vecs[3].ti)
                         + int'(vecs[3].tf)) % 256);
        vecs[3].mode = 0;
        vecs[3].low_us = int'($urandom_range(520, 640));
        vecs[4] = '{hi:8'h37, hf:8'h00, ti:8'h19, tf:8'h00, cs:8'h50, mode:1, low_us:600};

        // Reset state, with the host already holding the line low.
        repeat (3) @(negedge CLK);
        chk("reset DATA_OE", int'(DATA_OE), 0, 0);
        chk("reset BUSY", int'(BUSY), 0, 0);
        chk("reset FRAME_DONE", int'(FRAME_DONE), 0, 0);
        chk("reset COLLISION", int'(COLLISION), 0, 0);

        // A low already present at reset release is not a start request.
        @(posedge CLK); #1 RST = 1'b1;
        repeat (600 * K) @(posedge CLK);
        #1 host_low = 1'b0;
        watch_quiet("stale low after reset", 400);

        // Too-short host pulse is ignored.
        host_start(200);
        watch_quiet("short start pulse", 400);

        foreach (vecs[v]) begin
            HUM_INT = vecs[v].hi; HUM_FLOAT = vecs[v].hf;
            TEMP_INT = vecs[v].ti; TEMP_FLOAT = vecs[v].tf;
            host_start(vecs[v].low_us);
            capture(vecs[v].mode);
            check_frame({vecs[v].hi, vecs[v].hf, vecs[v].ti, vecs[v].tf, vecs[v].cs},
                        $sformatf("vec%0d", v));
            repeat (20) @(posedge CLK);
        end

        // Host grabs the line for 5 us in the released half of bit 10.
        HUM_INT = 8'h12; HUM_FLOAT = 8'h34; TEMP_INT = 8'h56; TEMP_FLOAT = 8'h78;
        host_start(550);
        capture(2);
        chk("coll injected", int'(coll_at >= 0), 1, 1);
        chk("coll count", n_coll, 1, 1);
        chk("coll latency", coll_idx - coll_at, 3, 5);
        chk("coll busy", busy_at_coll, 0, 0);
        chk("coll no frame_done", n_done, 0, 0);
        chk("coll drive after abort", oe_after_coll, 0, 0);
        repeat (20) @(posedge CLK);

        // Reset during the ack drive releases the bus without a clock edge.
        host_start(550);
        begin
            int t = 0;
            while (!DATA_OE && t < 400) begin @(negedge CLK); t++; end
            chk("rst ack drive seen", int'(DATA_OE), 1, 1);
        end
        repeat (20) @(negedge CLK);
        @(posedge CLK); #2 RST = 1'b0; #1;
        chk("rst DATA_OE immediate", int'(DATA_OE), 0, 0);
        chk("rst BUSY immediate", int'(BUSY), 0, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        watch_quiet("no resume after reset", 400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
